// File: rtl/iq_mixer_acc.sv
// iq_mixer_acc: IQ downconversion mixer with windowed integrate-and-dump.
// Three-stage pipeline: sample capture, full-precision multiply, accumulate.
module iq_mixer_acc #(
    parameter int ADC_DATA_WIDTH       = 12,
    parameter int SIN_TABLE_DATA_WIDTH = 13,
    parameter int WINDOW_BITS          = 10,
    localparam int ACC_WIDTH = ADC_DATA_WIDTH + SIN_TABLE_DATA_WIDTH
                             + WINDOW_BITS
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic                                   CE,
    input  logic signed [ADC_DATA_WIDTH-1:0]       ADC_VALUE,
    input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] SIN_VALUE,
    input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] COS_VALUE,
    input  logic                                   IN_VALID,
    input  logic                                   SYNC,
    output logic signed [ACC_WIDTH-1:0]            I_OUT,
    output logic signed [ACC_WIDTH-1:0]            Q_OUT,
    output logic                                   OUT_VALID
);

    localparam int PW = ADC_DATA_WIDTH + SIN_TABLE_DATA_WIDTH;

    typedef struct packed {
        logic                                   vld;
        logic signed [ADC_DATA_WIDTH-1:0]       adc;
        logic signed [SIN_TABLE_DATA_WIDTH-1:0] sin;
        logic signed [SIN_TABLE_DATA_WIDTH-1:0] cos;
    } s1_t;

    typedef struct packed {
        logic                 vld;
        logic signed [PW-1:0] i_p;
        logic signed [PW-1:0] q_p;
    } s2_t;

    s1_t s1_q;
    s2_t s2_q;

    logic signed [PW-1:0]        i_mul;
    logic signed [PW-1:0]        q_mul;
    logic signed [ACC_WIDTH-1:0] i_acc;
    logic signed [ACC_WIDTH-1:0] q_acc;
    logic signed [ACC_WIDTH-1:0] i_sum;
    logic signed [ACC_WIDTH-1:0] q_sum;
    logic [WINDOW_BITS-1:0]      cnt;
    logic                        last;

    // Operands are sign-extended to product width so nothing is lost.
    always_comb begin
        i_mul = PW'($signed(s1_q.adc)) * PW'($signed(s1_q.cos));
        q_mul = PW'($signed(s1_q.adc)) * PW'($signed(s1_q.sin));
        i_sum = i_acc + {{WINDOW_BITS{s2_q.i_p[PW-1]}}, s2_q.i_p};
        q_sum = q_acc + {{WINDOW_BITS{s2_q.q_p[PW-1]}}, s2_q.q_p};
        last  = s2_q.vld && (cnt == '1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q <= '0;
        end else if (CE) begin
            s1_q.vld <= IN_VALID;
            if (IN_VALID) begin
                s1_q.adc <= ADC_VALUE;
                s1_q.sin <= SIN_VALUE;
                s1_q.cos <= COS_VALUE;
            end
        end
    end

    // SYNC drops the sample leaving stage 1; the one entering it survives.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s2_q <= '0;
        end else if (CE) begin
            s2_q.vld <= s1_q.vld && !SYNC;
            if (s1_q.vld) begin
                s2_q.i_p <= i_mul;
                s2_q.q_p <= q_mul;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            i_acc     <= '0;
            q_acc     <= '0;
            cnt       <= '0;
            I_OUT     <= '0;
            Q_OUT     <= '0;
            OUT_VALID <= 1'b0;
        end else if (!CE) begin
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            if (SYNC) begin
                i_acc <= '0;
                q_acc <= '0;
                cnt   <= '0;
            end else if (last) begin
                I_OUT     <= i_sum;
                Q_OUT     <= q_sum;
                OUT_VALID <= 1'b1;
                i_acc     <= '0;
                q_acc     <= '0;
                cnt       <= '0;
            end else if (s2_q.vld) begin
                i_acc <= i_sum;
                q_acc <= q_sum;
                cnt   <= cnt + WINDOW_BITS'(1);
            end
        end
    end

endmodule

// File: doc/iq_mixer_acc.md
IQ_MIXER_ACC -- requirements
Module: iq_mixer_acc

Interface
REQ-001 SHALL have parameter ADC_DATA_WIDTH, default 12, meaning signed input sample width.
REQ-002 SHALL have parameter SIN_TABLE_DATA_WIDTH, default 13, meaning signed sine/cosine reference width.
REQ-003 SHALL have parameter WINDOW_BITS, default 10, meaning accumulation window of 2^WINDOW_BITS accepted samples.
REQ-004 SHALL derive localparam ACC_WIDTH = ADC_DATA_WIDTH+SIN_TABLE_DATA_WIDTH+WINDOW_BITS.
REQ-005 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-007 SHALL have port CE  input  1  clock enable.
REQ-008 SHALL have port ADC_VALUE  input  ADC_DATA_WIDTH  signed sample.
REQ-009 SHALL have port SIN_VALUE  input  SIN_TABLE_DATA_WIDTH  signed reference sine, from the DCO.
REQ-010 SHALL have port COS_VALUE  input  SIN_TABLE_DATA_WIDTH  signed reference cosine, from the DCO.
REQ-011 SHALL have port IN_VALID  input  1  sample qualifier.
REQ-012 SHALL have port SYNC  input  1  window restart request.
REQ-013 SHALL have port I_OUT  output  ACC_WIDTH  signed in-phase window sum.
REQ-014 SHALL have port Q_OUT  output  ACC_WIDTH  signed quadrature window sum.
REQ-015 SHALL have port OUT_VALID  output  1  one-cycle strobe marking new I_OUT/Q_OUT.

Function
REQ-016 SHALL accept a sample on a rising edge where CE=1 and IN_VALID=1; stage 1 SHALL register ADC_VALUE, SIN_VALUE, COS_VALUE and a valid bit.
REQ-017 Stage 2 SHALL register full-precision signed products I_P = ADC*COS and Q_P = ADC*SIN, each ADC_DATA_WIDTH+SIN_TABLE_DATA_WIDTH bits, plus the valid bit.
REQ-018 Stage 3 SHALL add valid products into ACC_WIDTH sign-extended accumulators and increment a WINDOW_BITS-wide sample counter.
REQ-019 When the counter equals 2^WINDOW_BITS-1 and stage 2 is valid, stage 3 SHALL load I_OUT/Q_OUT with accumulator+product, zero the accumulators and counter (wrap), and set OUT_VALID=1.
REQ-020 Latency: last window sample accepted at edge N SHALL make I_OUT/Q_OUT/OUT_VALID visible after edge N+2.
REQ-021 OUT_VALID SHALL be high for exactly one cycle per completed window; I_OUT/Q_OUT SHALL hold between strobes.
REQ-022 With CE=0, all pipeline, accumulator, counter and output registers SHALL hold, except OUT_VALID, which SHALL be cleared to 0.
REQ-023 Cycles with IN_VALID=0 SHALL not advance the counter or accumulators; gaps SHALL not change the result.
REQ-024 With SYNC=1 and CE=1, the block SHALL zero the accumulators and counter, clear the stage 1/2 valid bits, and not assert OUT_VALID, even if a window would have completed that edge.
REQ-025 A sample presented with IN_VALID=1 in the same cycle as SYNC SHALL be accepted as the first sample of the new window.
REQ-026 Accumulators SHALL never overflow; the extreme case 2^WINDOW_BITS x (-2^(ADC-1))x(-2^(SIN-1)) fits ACC_WIDTH signed.
REQ-027 The block SHALL perform no rounding or truncation anywhere in the datapath.

Reset
REQ-028 RESET=1 at an edge SHALL zero I_OUT, Q_OUT, OUT_VALID, the accumulators, the counter, and all pipeline registers and valid bits, regardless of CE.
REQ-029 RESET mid-window SHALL discard the partial window and all in-flight samples; no OUT_VALID SHALL be asserted for them.
REQ-030 The first window after RESET deasserts SHALL start with the first sample accepted.

Verification (WINDOW_BITS=2, other parameters default)
REQ-031 Bench SHALL cover: reset held 5 cycles -> I_OUT=0, Q_OUT=0, OUT_VALID=0.
REQ-032 Bench SHALL cover: ADC=100, SIN=0, COS=4095, IN_VALID for 4 consecutive cycles (last at edge N) -> after edge N+2, I_OUT=1638000, Q_OUT=0, OUT_VALID=1 for one cycle only.
REQ-033 Bench SHALL cover: same 4 samples with IN_VALID gaps of 1-3 cycles plus a CE=0 stall of 3 cycles -> identical I_OUT/Q_OUT, one strobe, OUT_VALID=0 during the stall.
REQ-034 Bench SHALL cover: ADC=-2048, SIN=-4096, COS=-4096, 4 samples -> I_OUT=Q_OUT=33554432, no overflow.
REQ-035 Bench SHALL cover: 2 samples (ADC=10, SIN=3, COS=-5), then SYNC with a concurrent sample, then 3 more -> a single strobe with I_OUT=-200, Q_OUT=120.
REQ-036 Bench SHALL cover: RESET after 3 of 4 samples, then 4 fresh samples (ADC=1, SIN=1, COS=1) -> no strobe from the partial window; next strobe I_OUT=Q_OUT=4.
